// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry/execute stage.
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    GOT_A,
    GOT_OP,
    EXEC,
    DONE
  } state_t;

  localparam logic [1:0] PHASE_IDLE   = 2'd0;
  localparam logic [1:0] PHASE_GOT_A  = 2'd1;
  localparam logic [1:0] PHASE_GOT_OP = 2'd2;
  localparam logic [1:0] PHASE_EXEC   = 2'd3;

  // DONE shares the IDLE code so the display shows "ready for A" after a result.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      GOT_A:   return PHASE_GOT_A;
      GOT_OP:  return PHASE_GOT_OP;
      EXEC:    return PHASE_EXEC;
      default: return PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_seq_if.sv
// Entry/result bundle between the pin-level wrapper and calc_entry_seq.
interface calc_entry_seq_if #(
  parameter int WIDTH = calc_pkg::CALC_WIDTH
);
  logic [WIDTH-1:0] entry_data;
  logic             entry_stb;
  logic             clear;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic             carry;
  logic             err;
  logic [1:0]       phase;

  modport master (
    output entry_data, entry_stb, clear,
    input  result, result_valid, busy, carry, err, phase
  );

  modport slave (
    input  entry_data, entry_stb, clear,
    output result, result_valid, busy, carry, err, phase
  );
endinterface

// File: rtl/calc_stb_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module calc_stb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      level_q <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
      level_q <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign level = sync_ff[SYNC_STAGES-1];
  assign pulse = sync_ff[SYNC_STAGES-1] & ~level_q;

endmodule

// File: rtl/calc_entry_seq.sv
// Operand entry (A, op, B via strobed bytes) and execution: 1-cycle add/sub,
// WIDTH-cycle shift-add multiply and restoring divide.
//
// state  | meaning
// IDLE   | waiting for operand A
// GOT_A  | A held, waiting for opcode
// GOT_OP | opcode held, waiting for operand B
// EXEC   | computing; busy high
// DONE   | result and flags valid; next strobe starts a new A
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int WIDTH       = CALC_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  input logic            ena,
  calc_entry_seq_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic stb_level, stb_pulse, clr_level, clr_pulse;
  logic unused_sync;

  calc_stb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.entry_stb),
    .level    (stb_level),
    .pulse    (stb_pulse)
  );

  calc_stb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.clear),
    .level    (clr_level),
    .pulse    (clr_pulse)
  );

  assign unused_sync = &{1'b0, stb_level, clr_pulse};

  state_t           state;
  op_t              op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result_q;
  logic             valid_q, busy_q, carry_q, err_q;
  logic [1:0]       phase_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic             exec_last;

  // MUL: {acc_hi,acc_lo} starts as {0,B}; each step adds A on the LSB and shifts right.
  // DIV: acc_hi is the running remainder, acc_lo shifts the dividend out and quotient in.
  always_comb begin
    add_sum    = {1'b0, a_reg} + {1'b0, b_reg};
    sub_diff   = a_reg - b_reg;
    sub_borrow = (a_reg < b_reg);

    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_reg} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

    exec_last = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: exec_last = 1'b1;
      OP_MUL:         exec_last = (cnt == CNT_LAST);
      default:        exec_last = (b_reg == '0) || (cnt == CNT_LAST);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_reg   <= OP_ADD;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= PHASE_IDLE;
    end else if (ena) begin
      if (clr_level) begin
        state    <= IDLE;
        cnt      <= '0;
        result_q <= '0;
        valid_q  <= 1'b0;
        busy_q   <= 1'b0;
        carry_q  <= 1'b0;
        err_q    <= 1'b0;
        phase_q  <= PHASE_IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (stb_pulse) begin
              a_reg   <= bus.entry_data;
              state   <= GOT_A;
              phase_q <= phase_of(GOT_A);
            end
          end

          GOT_A: begin
            if (stb_pulse) begin
              op_reg  <= op_t'(bus.entry_data[1:0]);
              state   <= GOT_OP;
              phase_q <= phase_of(GOT_OP);
            end
          end

          GOT_OP: begin
            if (stb_pulse) begin
              b_reg   <= bus.entry_data;
              acc_hi  <= '0;
              acc_lo  <= (op_reg == OP_MUL) ? bus.entry_data : a_reg;
              cnt     <= '0;
              busy_q  <= 1'b1;
              state   <= EXEC;
              phase_q <= phase_of(EXEC);
            end
          end

          EXEC: begin
            case (op_reg)
              OP_ADD: {carry_q, result_q} <= add_sum;
              OP_SUB: begin
                result_q <= sub_diff;
                carry_q  <= sub_borrow;
              end
              OP_MUL: begin
                acc_hi <= mul_hi_n;
                acc_lo <= mul_lo_n;
                cnt    <= cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                  result_q <= mul_lo_n;
                  carry_q  <= |mul_hi_n;
                end
              end
              default: begin
                if (b_reg == '0) begin
                  result_q <= '1;
                  err_q    <= 1'b1;
                end else begin
                  acc_hi <= div_hi_n;
                  acc_lo <= div_lo_n;
                  cnt    <= cnt + CW'(1);
                  if (cnt == CNT_LAST) result_q <= div_lo_n;
                end
              end
            endcase
            if (exec_last) begin
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              state   <= DONE;
              phase_q <= phase_of(DONE);
            end
          end

          DONE: begin
            if (stb_pulse) begin
              a_reg   <= bus.entry_data;
              valid_q <= 1'b0;
              carry_q <= 1'b0;
              err_q   <= 1'b0;
              state   <= GOT_A;
              phase_q <= phase_of(GOT_A);
            end
          end

          default: begin
            state   <= IDLE;
            phase_q <= PHASE_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.carry        = carry_q;
  assign bus.err          = err_q;
  assign bus.phase        = phase_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Scoreboard bench for calc_entry_seq: expected results queued at stimulus time, popped on result_valid.
module tb_calc_entry_seq;
  import calc_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  calc_entry_seq_if #(.WIDTH(W)) bus ();

  calc_entry_seq #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic [W-1:0] a, input op_t op, input logic [W-1:0] b);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    exp_t           e;
    e = '0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.carry = s[W]; end
      OP_SUB: begin e.res = a - b; e.carry = (a < b); end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.carry = |p[2*W-1:W];
      end
      default: begin
        if (b == '0) begin e.res = '1; e.err = 1'b1; end
        else e.res = a / b;
      end
    endcase
    return e;
  endfunction

  task automatic strobe(input logic [W-1:0] d);
    @(negedge clk);
    bus.entry_data = d;
    bus.entry_stb  = 1'b1;
    repeat (4) @(negedge clk);
    bus.entry_stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Strobes B, then reports busy cycles, cycles from first busy to result_valid, and timeout.
  task automatic send_b(input logic [W-1:0] d, output int busy_cnt, output int lat, output bit tmo);
    int first_busy;
    first_busy = -1;
    busy_cnt = 0;
    lat = 0;
    tmo = 1'b1;
    @(negedge clk);
    bus.entry_data = d;
    bus.entry_stb  = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 4) bus.entry_stb = 1'b0;
      if (bus.busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (bus.result_valid && first_busy >= 0) begin
        lat = i - first_busy;
        tmo = 1'b0;
        break;
      end
    end
    bus.entry_stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input op_t op, input logic [W-1:0] b,
                        output int busy_cnt, output int lat, output bit tmo);
    strobe(a);
    strobe({{(W-2){1'b0}}, op});
    sb_q.push_back(model(a, op, b));
    send_b(b, busy_cnt, lat, tmo);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.result, bus.result_valid, bus.busy, bus.carry, bus.err, bus.phase} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got res=%0h v=%b b=%b c=%b e=%b ph=%0d exp all zero",
               bus.result, bus.result_valid, bus.busy, bus.carry, bus.err, bus.phase);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.phase !== PHASE_IDLE || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ph=%0d v=%b exp ph=0 v=0", bus.phase, bus.result_valid);
    end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] ta[4] = '{8'd25, 8'd200, 8'd5, 8'd9};
    logic [W-1:0] tb[4] = '{8'd17, 8'd100, 8'd9, 8'd5};
    op_t          to[4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    int bc, lat;
    bit tmo;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], to[i], tb[i], bc, lat, tmo);
      e = sb_q.pop_front();
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL addsub_done[%0d] timeout waiting for result_valid", i);
      end else begin
        checks++;
        if (bus.result !== e.res || bus.carry !== e.carry || bus.err !== e.err) begin
          errors++;
          $display("FAIL addsub_result[%0d] got res=%0h c=%b e=%b exp res=%0h c=%b e=%b",
                   i, bus.result, bus.carry, bus.err, e.res, e.carry, e.err);
        end
        checks++;
        if (lat !== 1 || bc !== 1) begin
          errors++;
          $display("FAIL addsub_latency[%0d] got lat=%0d busy=%0d exp lat=1 busy=1", i, lat, bc);
        end
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ta[2] = '{8'd13, 8'd20};
    logic [W-1:0] tb[2] = '{8'd11, 8'd20};
    int bc, lat;
    bit tmo;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], OP_MUL, tb[i], bc, lat, tmo);
      e = sb_q.pop_front();
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL mul_done[%0d] timeout waiting for result_valid", i);
      end else begin
        checks++;
        if (bus.result !== e.res || bus.carry !== e.carry) begin
          errors++;
          $display("FAIL mul_result[%0d] got res=%0h c=%b exp res=%0h c=%b",
                   i, bus.result, bus.carry, e.res, e.carry);
        end
        checks++;
        if (bc !== W || lat !== W) begin
          errors++;
          $display("FAIL mul_busy[%0d] got busy=%0d lat=%0d exp %0d", i, bc, lat, W);
        end
      end
    end
  endtask

  task automatic test_done_strobe();
    int bc, lat;
    bit tmo;
    exp_t e;
    strobe(8'd3);
    checks++;
    if (bus.phase !== PHASE_GOT_A || bus.result_valid !== 1'b0 || bus.carry !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL done_strobe got ph=%0d v=%b c=%b e=%b exp ph=1 v=0 c=0 e=0",
               bus.phase, bus.result_valid, bus.carry, bus.err);
    end
    strobe({{(W-2){1'b0}}, OP_ADD});
    sb_q.push_back(model(8'd3, OP_ADD, 8'd4));
    send_b(8'd4, bc, lat, tmo);
    e = sb_q.pop_front();
    checks++;
    if (tmo || bus.result !== e.res) begin
      errors++;
      $display("FAIL done_newA got res=%0h tmo=%b exp res=%0h", bus.result, tmo, e.res);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta[2] = '{8'd200, 8'd50};
    logic [W-1:0] tb[2] = '{8'd7, 8'd0};
    int           eb[2] = '{W, 1};
    int bc, lat;
    bit tmo;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], OP_DIV, tb[i], bc, lat, tmo);
      e = sb_q.pop_front();
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL div_done[%0d] timeout waiting for result_valid", i);
      end else begin
        checks++;
        if (bus.result !== e.res || bus.err !== e.err || bus.carry !== e.carry) begin
          errors++;
          $display("FAIL div_result[%0d] got res=%0h e=%b c=%b exp res=%0h e=%b c=%b",
                   i, bus.result, bus.err, bus.carry, e.res, e.err, e.carry);
        end
        checks++;
        if (bc !== eb[i]) begin
          errors++;
          $display("FAIL div_busy[%0d] got %0d exp %0d", i, bc, eb[i]);
        end
      end
    end
  endtask

  task automatic test_exec_strobe();
    int   bc;
    bit   done, phase_bad;
    exp_t e;
    bc = 0;
    done = 1'b0;
    phase_bad = 1'b0;
    strobe(8'd13);
    strobe({{(W-2){1'b0}}, OP_MUL});
    sb_q.push_back(model(8'd13, OP_MUL, 8'd11));
    @(negedge clk);
    bus.entry_data = 8'd11;
    bus.entry_stb  = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 4) bus.entry_stb = 1'b0;
      if (i == 5) begin bus.entry_data = 8'hAA; bus.entry_stb = 1'b1; end
      if (i == 7) bus.entry_stb = 1'b0;
      if (bus.busy) begin
        bc++;
        if (bus.phase !== PHASE_EXEC) phase_bad = 1'b1;
      end
      if (bus.result_valid) begin done = 1'b1; break; end
    end
    bus.entry_stb = 1'b0;
    repeat (4) @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (!done || bus.result !== e.res || bc !== W) begin
      errors++;
      $display("FAIL exec_strobe got done=%b res=%0h busy=%0d exp res=%0h busy=%0d",
               done, bus.result, bc, e.res, W);
    end
    checks++;
    if (phase_bad !== 1'b0 || bus.phase !== PHASE_IDLE) begin
      errors++;
      $display("FAIL exec_strobe_phase got bad=%b ph=%0d exp bad=0 ph=0", phase_bad, bus.phase);
    end
  endtask

  task automatic test_rst_mid_div();
    int bc;
    bit hit;
    bc = 0;
    hit = 1'b0;
    strobe(8'd200);
    strobe({{(W-2){1'b0}}, OP_DIV});
    @(negedge clk);
    bus.entry_data = 8'd7;
    bus.entry_stb  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) bus.entry_stb = 1'b0;
      if (bus.busy) bc++;
      if (bc == 4) begin
        bus.entry_stb = 1'b0;
        rst_n = 1'b0;
        #1;
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_div never reached busy cycle 4 (busy=%0d)", bc);
    end else begin
      checks++;
      if ({bus.result, bus.result_valid, bus.busy, bus.carry, bus.err, bus.phase} !== '0) begin
        errors++;
        $display("FAIL rst_mid_div got res=%0h v=%b b=%b c=%b e=%b ph=%0d exp all zero",
                 bus.result, bus.result_valid, bus.busy, bus.carry, bus.err, bus.phase);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear();
    int bc, lat;
    bit tmo;
    exp_t e;
    strobe(8'd10);
    strobe({{(W-2){1'b0}}, OP_SUB});
    checks++;
    if (bus.phase !== PHASE_GOT_OP) begin
      errors++;
      $display("FAIL clear_setup got ph=%0d exp 2", bus.phase);
    end
    @(negedge clk);
    bus.clear = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.phase !== PHASE_IDLE || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got ph=%0d v=%b b=%b exp ph=0 v=0 b=0", bus.phase, bus.result_valid, bus.busy);
    end
    strobe(8'd99);
    checks++;
    if (bus.phase !== PHASE_IDLE) begin
      errors++;
      $display("FAIL clear_hold_strobe got ph=%0d exp 0", bus.phase);
    end
    bus.clear = 1'b0;
    repeat (4) @(negedge clk);
    run_op(8'd7, OP_ADD, 8'd8, bc, lat, tmo);
    e = sb_q.pop_front();
    checks++;
    if (tmo || bus.result !== e.res) begin
      errors++;
      $display("FAIL clear_newA got res=%0h tmo=%b exp res=%0h", bus.result, tmo, e.res);
    end
  endtask

  task automatic test_ena();
    int bc, lat;
    bit tmo;
    exp_t e;
    @(negedge clk);
    ena = 1'b0;
    strobe(8'd50);
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.phase !== PHASE_IDLE || bus.result_valid !== 1'b1 || bus.result !== 8'd15) begin
      errors++;
      $display("FAIL ena_hold got ph=%0d v=%b res=%0d exp ph=0 v=1 res=15",
               bus.phase, bus.result_valid, bus.result);
    end
    run_op(8'd6, OP_MUL, 8'd7, bc, lat, tmo);
    e = sb_q.pop_front();
    checks++;
    if (tmo || bus.result !== e.res || bus.carry !== e.carry) begin
      errors++;
      $display("FAIL ena_after got res=%0d c=%b tmo=%b exp res=%0d c=%b",
               bus.result, bus.carry, tmo, e.res, e.carry);
    end
  endtask

  initial begin
    bus.entry_data = '0;
    bus.entry_stb  = 1'b0;
    bus.clear      = 1'b0;
    test_reset();
    test_add_sub();
    test_mul();
    test_done_strobe();
    test_div();
    test_exec_strobe();
    test_rst_mid_div();
    test_clear();
    test_ena();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
